rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 102 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges ALU and memory-load results onto one RF write port.
// Define RF_WB_ROUND_ROBIN_EN for alternating grants; default is fixed M priority.
module rf_wb_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          freeze,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          a_cout_en,
  input  logic [DW-1:0] a_cout_data,
  input  logic          m_valid,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic          m_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_cout_we,
  output logic [DW-1:0] rf_cout_data,
  output logic [7:0]    conflict_cnt
);

  logic both;
  logic m_wins;
  logic sel_m;
  logic sel_a;
  logic m_gnt;
  logic a_gnt;

`ifdef RF_WB_ROUND_ROBIN_EN
  logic ptr_m;

  assign m_wins = ptr_m;

  // Pointer names the side favoured on the next simultaneous request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_m <= 1'b1;
    end else if (m_gnt) begin
      ptr_m <= 1'b0;
    end else if (a_gnt) begin
      ptr_m <= 1'b1;
    end
  end
`else
  assign m_wins = 1'b1;
`endif

  assign both  = a_valid & m_valid;
  assign sel_m = m_valid & (~a_valid | m_wins);
  assign sel_a = a_valid & (~m_valid | ~m_wins);

  always_comb begin
    m_gnt = 1'b0;
    a_gnt = 1'b0;
    unique case (1'b1)
      sel_m:   m_gnt = rst_n & ~freeze;
      sel_a:   a_gnt = rst_n & ~freeze;
      default: ;
    endcase
  end

  assign m_ready = m_gnt;
  assign a_ready = a_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_cout_we   <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_cout_data <= '0;
    end else begin
      rf_we      <= m_gnt | a_gnt;
      rf_cout_we <= a_gnt & a_cout_en;
      if (m_gnt) begin
        rf_waddr <= m_addr;
        rf_wdata <= m_data;
      end else if (a_gnt) begin
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end
      if (a_gnt && a_cout_en) begin
        rf_cout_data <= a_cout_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (both && !freeze && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter.
// Expected behaviour comes from a grant-rule model, not from the RTL.
module tb_rf_wb_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          freeze;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          a_cout_en;
  logic [DW-1:0] a_cout_data;
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_cout_we;
  logic [DW-1:0] rf_cout_data;
  logic [7:0]    conflict_cnt;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .a_ready(a_ready), .a_cout_en(a_cout_en),
    .a_cout_data(a_cout_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_cout_we(rf_cout_we), .rf_cout_data(rf_cout_data),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: what the write port must show after the next edge
  bit       e_we, e_cwe;
  int       e_waddr, e_wdata, e_cdata, e_cnt;
  bit       m_turn;
  bit       ga, gm;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle; called just after a negedge with inputs set
  task automatic tick(output bit g_a, output bit g_m);
    #1;
    if (!rst_n) begin
      e_we = 0; e_cwe = 0; e_waddr = 0; e_wdata = 0;
      e_cdata = 0; e_cnt = 0; m_turn = 1;
    end
    check("rf_we", rf_we, e_we);
    check("rf_cout_we", rf_cout_we, e_cwe);
    check("rf_waddr", rf_waddr, e_waddr);
    check("rf_wdata", rf_wdata, e_wdata);
    check("rf_cout_data", rf_cout_data, e_cdata);
    check("conflict_cnt", conflict_cnt, e_cnt);
    g_m = rst_n && !freeze && m_valid && (!a_valid || m_turn);
    g_a = rst_n && !freeze && a_valid && !g_m;
    check("a_ready", a_ready, g_a);
    check("m_ready", m_ready, g_m);
    if (rst_n) begin
      e_we  = g_a || g_m;
      e_cwe = g_a && a_cout_en;
      if (g_m) begin
        e_waddr = m_addr; e_wdata = m_data;
      end else if (g_a) begin
        e_waddr = a_addr; e_wdata = a_data;
      end
      if (g_a && a_cout_en) e_cdata = a_cout_data;
      if (a_valid && m_valid && !freeze && e_cnt < 255)
        e_cnt++;
`ifdef RF_WB_ROUND_ROBIN_EN
      if (g_m) m_turn = 0;
      else if (g_a) m_turn = 1;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(int ad, int d, bit ce, int cd);
    a_valid = 1; a_addr = AW'(ad); a_data = DW'(d);
    a_cout_en = ce; a_cout_data = DW'(cd);
  endtask

  task automatic set_m(int ad, int d);
    m_valid = 1; m_addr = AW'(ad); m_data = DW'(d);
  endtask

  task automatic do_reset();
    rst_n = 0; freeze = 0; a_valid = 0; m_valid = 0;
    tick(ga, gm);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; freeze = 0;
    a_valid = 0; a_addr = 0; a_data = 0;
    a_cout_en = 0; a_cout_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    m_turn = 1;
    @(negedge clk);
    do_reset();

    // Single A request with COUT update
    set_a(2, 8'h5A, 1, 8'h01);
    #1 check("r032_a_ready", a_ready, 1);
    tick(ga, gm);
    a_valid = 0;
    check("r032_we", rf_we, 1);
    check("r032_waddr", rf_waddr, 2);
    check("r032_wdata", rf_wdata, 8'h5A);
    check("r032_cwe", rf_cout_we, 1);
    check("r032_cdata", rf_cout_data, 8'h01);
    tick(ga, gm);
    check("r032_pulse", rf_we, 0);

    // Simultaneous same-address requests
    do_reset();
    set_a(1, 8'h11, 0, 0);
    set_m(1, 8'h22);
    #1 check("both_m_first", m_ready, 1);
`ifdef RF_WB_ROUND_ROBIN_EN
    tick(ga, gm);
    m_valid = 0;
    check("r033_wd_m", rf_wdata, 8'h22);
    check("r033_cwe_m", rf_cout_we, 0);
    tick(ga, gm);
    a_valid = 0;
    check("r033_wd_a", rf_wdata, 8'h11);
    check("r033_cnt", conflict_cnt, 1);
`else
    for (int i = 0; i < 3; i++) begin
      set_m(1, 8'h22 + i);
      tick(ga, gm);
      check("r034_wd_m", rf_wdata, 8'h22 + i);
    end
    m_valid = 0;
    tick(ga, gm);
    a_valid = 0;
    check("r034_wd_a", rf_wdata, 8'h11);
    check("r034_cnt", conflict_cnt, 3);
`endif
    tick(ga, gm);

    // Freeze with both valid
    do_reset();
    set_a(3, 8'h33, 1, 8'h44);
    set_m(0, 8'h55);
    freeze = 1;
    for (int i = 0; i < 2; i++) tick(ga, gm);
    check("r035_no_we", rf_we, 0);
    check("r035_cnt", conflict_cnt, 0);
    freeze = 0;
    for (int i = 0; i < 4; i++) begin
      tick(ga, gm);
      if (ga) a_valid = 0;
      if (gm) m_valid = 0;
    end
    check("r035_drained", {a_valid, m_valid}, 0);

    // Reset in the cycle after an M transfer
    do_reset();
    set_m(2, 8'h77);
    tick(ga, gm);
    m_valid = 0;
    check("r036_we_before", rf_we, 1);
    rst_n = 0;
    #1;
    check("r036_we", rf_we, 0);
    check("r036_wd", rf_wdata, 0);
    check("r036_wa", rf_waddr, 0);
    tick(ga, gm);
    rst_n = 1;
    tick(ga, gm);
    check("r036_no_write", rf_we, 0);

    // Counter saturation
    do_reset();
    set_a(0, 1, 0, 0);
    set_m(1, 2);
    for (int i = 0; i < 300; i++) begin
      tick(ga, gm);
      if (ga) set_a($urandom_range(3), $urandom, $urandom_range(1), $urandom);
      if (gm) set_m($urandom_range(3), $urandom);
    end
    check("r037_sat", conflict_cnt, 255);

    // Random traffic with holds, freezes and occasional resets
    do_reset();
    a_valid = 0; m_valid = 0;
    for (int i = 0; i < 800; i++) begin
      if (!a_valid && $urandom_range(2) != 0)
        set_a($urandom_range(3), $urandom, $urandom_range(1), $urandom);
      if (!m_valid && $urandom_range(2) != 0)
        set_m($urandom_range(3), $urandom);
      freeze = ($urandom_range(5) == 0);
      rst_n  = ($urandom_range(99) != 0);
      tick(ga, gm);
      if (ga) a_valid = 0;
      if (gm) m_valid = 0;
    end
    rst_n = 1; freeze = 0; a_valid = 0; m_valid = 0;
    tick(ga, gm);
    tick(ga, gm);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
